// File: rtl/acc_datapath_gen_pkg.sv
// Shared types and default sizes for the accumulator datapath and its
// instruction fetch unit.
package acc_datapath_gen_pkg;

  localparam int WIDTH_DEF       = 8;
  localparam int INSTR_BYTES_DEF = 4;
  localparam int STACK_DEPTH_DEF = 8;

  typedef enum logic [2:0] {
    OP_NOP  = 3'd0,
    OP_LDAB = 3'd1,
    OP_LDBB = 3'd2,
    OP_ADD  = 3'd3,
    OP_SUB  = 3'd4,
    OP_PUSH = 3'd5,
    OP_POP  = 3'd6,
    OP_SHL  = 3'd7
  } exec_op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DONE  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/acc_datapath_gen_lifo_stack.sv
// LIFO stack for the accumulator: refuses overflow/underflow and flags them
// on a sticky error bit; full/empty are registered.
module lifo_stack #(
  parameter int WIDTH       = 8,
  parameter int STACK_DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             err_clr,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic             err
);

  localparam int CW = $clog2(STACK_DEPTH) + 1;

  logic [WIDTH-1:0] mem [STACK_DEPTH];
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_next;
  logic [CW-2:0]    top_idx;
  logic             do_push;
  logic             do_pop;
  logic             bad;

  assign top_idx  = count[CW-2:0] - 1'b1;
  assign pop_data = mem[top_idx];

  always_comb begin
    do_push    = push && !full;
    do_pop     = pop && !push && !empty;
    bad        = (push && full) || (pop && !push && empty);
    count_next = count;
    if (do_push) begin
      count_next = count + 1'b1;
    end else if (do_pop) begin
      count_next = count - 1'b1;
    end
  end

  // A new error in the same cycle as err_clr keeps the flag set.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
      err   <= 1'b0;
    end else begin
      count <= count_next;
      full  <= (count_next == CW'(STACK_DEPTH));
      empty <= (count_next == '0);
      if (bad) begin
        err <= 1'b1;
      end else if (err_clr) begin
        err <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[count[CW-2:0]] <= push_data;
    end
  end

endmodule

// File: rtl/acc_datapath_gen.sv
// Accumulator datapath: byte-serial instruction fetch FSM, ab/bb registers
// with ALU ops, status flags and an operand stack.
module acc_datapath_gen
  import acc_datapath_gen_pkg::*;
#(
  parameter int WIDTH       = WIDTH_DEF,
  parameter int INSTR_BYTES = INSTR_BYTES_DEF,
  parameter int STACK_DEPTH = STACK_DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     fetch_start,
  input  logic                     pc_load,
  input  logic [WIDTH-1:0]         pc_target,
  output logic                     mem_req,
  output logic [WIDTH-1:0]         mem_adr,
  input  logic                     mem_ack,
  input  logic [7:0]               mem_rdata,
  output logic [8*INSTR_BYTES-1:0] instr,
  output logic                     instr_valid,
  output logic                     busy,
  input  logic                     exec_valid,
  input  logic [2:0]               exec_op,
  input  logic                     err_clr,
  output logic [WIDTH-1:0]         ab,
  output logic [WIDTH-1:0]         bb,
  output logic                     zero,
  output logic                     carry,
  output logic                     stack_full,
  output logic                     stack_empty,
  output logic                     stack_err
);

  localparam int CW = $clog2(INSTR_BYTES);

  fetch_state_e     state;
  fetch_state_e     state_next;
  logic [WIDTH-1:0] pc;
  logic [CW-1:0]    cnt;
  logic             last_byte;
  logic             exec_fire;
  exec_op_e         op;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] pop_data;
  logic [WIDTH-1:0] ab_next;
  logic [WIDTH-1:0] bb_next;
  logic             carry_next;
  logic             ab_write;

  assign last_byte   = (cnt == CW'(INSTR_BYTES - 1));
  assign exec_fire   = (state == IDLE) && exec_valid;
  assign op          = exec_op_e'(exec_op);
  assign mem_req     = (state == FETCH);
  assign mem_adr     = pc;
  assign instr_valid = (state == DONE);
  assign busy        = (state != IDLE);
  assign sum         = {1'b0, ab} + {1'b0, bb};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (fetch_start) state_next = FETCH;
      FETCH:   if (mem_ack && last_byte) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // pc_load lands on the same edge that leaves IDLE, so a simultaneous
  // fetch_start reads from pc_target.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc    <= '0;
      cnt   <= '0;
      instr <= '0;
    end else if (state == IDLE) begin
      if (pc_load) pc <= pc_target;
      if (fetch_start) cnt <= '0;
    end else if (state == FETCH && mem_ack) begin
      instr[cnt*8 +: 8] <= mem_rdata;
      pc                <= pc + 1'b1;
      cnt               <= cnt + 1'b1;
    end
  end

  always_comb begin
    ab_next    = ab;
    bb_next    = bb;
    carry_next = carry;
    ab_write   = 1'b0;
    if (exec_fire) begin
      case (op)
        OP_LDAB: begin
          ab_next  = WIDTH'(instr[15:8]);
          ab_write = 1'b1;
        end
        OP_LDBB: bb_next = WIDTH'(instr[15:8]);
        OP_ADD: begin
          ab_next    = sum[WIDTH-1:0];
          carry_next = sum[WIDTH];
          ab_write   = 1'b1;
        end
        OP_SUB: begin
          ab_next    = ab - bb;
          carry_next = (ab < bb);
          ab_write   = 1'b1;
        end
        OP_POP: begin
          if (!stack_empty) begin
            ab_next  = pop_data;
            ab_write = 1'b1;
          end
        end
        OP_SHL: begin
          ab_next    = {ab[WIDTH-2:0], 1'b0};
          carry_next = ab[WIDTH-1];
          ab_write   = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ab    <= '0;
      bb    <= '0;
      zero  <= 1'b1;
      carry <= 1'b0;
    end else begin
      ab    <= ab_next;
      bb    <= bb_next;
      carry <= carry_next;
      if (ab_write) zero <= (ab_next == '0);
    end
  end

  lifo_stack #(
    .WIDTH       (WIDTH),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk       (clk),
    .reset     (reset),
    .push      (exec_fire && op == OP_PUSH),
    .pop       (exec_fire && op == OP_POP),
    .err_clr   (err_clr),
    .push_data (ab),
    .pop_data  (pop_data),
    .full      (stack_full),
    .empty     (stack_empty),
    .err       (stack_err)
  );

endmodule

// File: tb/tb_acc_datapath_gen.sv
// Directed testbench for acc_datapath_gen with a byte memory responder that
// can insert idle cycles before each ack.
module tb_acc_datapath_gen;
  import acc_datapath_gen_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_start, pc_load;
  logic [7:0]  pc_target;
  logic        mem_req;
  logic [7:0]  mem_adr;
  logic        mem_ack;
  logic [7:0]  mem_rdata;
  logic [31:0] instr;
  logic        instr_valid, busy;
  logic        exec_valid;
  logic [2:0]  exec_op;
  logic        err_clr;
  logic [7:0]  ab, bb;
  logic        zero, carry, stack_full, stack_empty, stack_err;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] mem [256];
  int         gaps [4];
  int         bi = 0, w = 0;
  logic [7:0] addr_log [64];
  int         addr_n = 0;
  int         req_drop = 0;
  int         pulses = 0;

  acc_datapath_gen dut (
    .clk(clk), .reset(reset), .fetch_start(fetch_start), .pc_load(pc_load),
    .pc_target(pc_target), .mem_req(mem_req), .mem_adr(mem_adr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .instr(instr),
    .instr_valid(instr_valid), .busy(busy), .exec_valid(exec_valid),
    .exec_op(exec_op), .err_clr(err_clr), .ab(ab), .bb(bb), .zero(zero),
    .carry(carry), .stack_full(stack_full), .stack_empty(stack_empty),
    .stack_err(stack_err)
  );

  always #5 clk = ~clk;

  // Memory responder: waits gaps[byte] idle cycles, then acks for one cycle.
  always @(negedge clk) begin
    if (!mem_req) begin
      mem_ack = 1'b0;
      bi = 0;
      w  = 0;
    end else if (w < gaps[bi]) begin
      mem_ack = 1'b0;
      w++;
    end else begin
      mem_ack   = 1'b1;
      mem_rdata = mem[mem_adr];
      if (addr_n < 64) addr_log[addr_n] = mem_adr;
      addr_n++;
      bi = (bi + 1) % 4;
      w  = 0;
    end
    if (busy && !instr_valid && !mem_req) req_drop++;
    if (instr_valid) pulses++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [2:0] op, input logic clr);
    exec_valid = 1'b1;
    exec_op    = op;
    err_clr    = clr;
    @(negedge clk);
    exec_valid = 1'b0;
    exec_op    = 3'd0;
    err_clr    = 1'b0;
  endtask

  // Starts a fetch (optionally with pc_load) and returns edges until instr_valid.
  task automatic doFetch(input logic load, input logic [7:0] target,
                         output int cycles, output int base);
    base        = addr_n;
    fetch_start = 1'b1;
    pc_load     = load;
    pc_target   = target;
    @(negedge clk);
    cycles      = 1;
    fetch_start = 1'b0;
    pc_load     = 1'b0;
    while (!instr_valid && cycles < 50) begin
      @(negedge clk);
      cycles++;
    end
    checkOutput("fetch_done", {31'd0, instr_valid}, 32'd1);
  endtask

  task automatic setGaps(input int g0, input int g1, input int g2, input int g3);
    gaps[0] = g0; gaps[1] = g1; gaps[2] = g2; gaps[3] = g3;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int cyc, base, drops, pb;
    logic [7:0] exp_adr [4];
    reset = 1'b0; fetch_start = 1'b0; pc_load = 1'b0; pc_target = 8'h00;
    exec_valid = 1'b0; exec_op = 3'd0; err_clr = 1'b0;
    mem_ack = 1'b0; mem_rdata = 8'h00;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h00] = 8'h11; mem[8'h01] = 8'h22; mem[8'h02] = 8'h33; mem[8'h03] = 8'h44;
    mem[8'h04] = 8'h11; mem[8'h05] = 8'h22; mem[8'h06] = 8'h33; mem[8'h07] = 8'h44;
    mem[8'hFE] = 8'hAA; mem[8'hFF] = 8'hF0;
    mem[8'h10] = 8'h01; mem[8'h11] = 8'h20; mem[8'h12] = 8'h02; mem[8'h13] = 8'h03;
    mem[8'h20] = 8'h04; mem[8'h21] = 8'h10; mem[8'h22] = 8'h05; mem[8'h23] = 8'h06;
    setGaps(0, 0, 0, 0);

    repeat (2) @(negedge clk);
    checkOutput("rst_ab", ab, 0);
    checkOutput("rst_bb", bb, 0);
    checkOutput("rst_instr", instr, 0);
    checkOutput("rst_flags", {zero, carry, stack_empty, stack_full, stack_err}, 5'b10100);
    checkOutput("rst_ctl", {mem_req, instr_valid, busy}, 3'b000);
    reset = 1'b1;
    @(negedge clk);

    // Back-to-back acks: pulse in the 6th cycle counting fetch_start's cycle as 1.
    doFetch(1'b0, 8'h00, cyc, base);
    checkOutput("f1_instr", instr, 32'h44332211);
    checkOutput("f1_cycles", cyc, 5);
    for (int i = 0; i < 4; i++) checkOutput("f1_adr", addr_log[base + i], i);
    @(negedge clk);
    checkOutput("f1_pulse_end", {instr_valid, busy}, 2'b00);

    // Gapped acks; first address 4 shows pc advanced to 4.
    setGaps(0, 3, 1, 2);
    drops = req_drop;
    doFetch(1'b0, 8'h00, cyc, base);
    checkOutput("f2_instr", instr, 32'h44332211);
    checkOutput("f2_cycles", cyc, 11);
    checkOutput("f2_req_drop", req_drop - drops, 0);
    for (int i = 0; i < 4; i++) checkOutput("f2_adr", addr_log[base + i], 4 + i);
    @(negedge clk);
    setGaps(0, 0, 0, 0);

    // pc_load with fetch_start: wrap through FF -> 00.
    exp_adr[0] = 8'hFE; exp_adr[1] = 8'hFF; exp_adr[2] = 8'h00; exp_adr[3] = 8'h01;
    doFetch(1'b1, 8'hFE, cyc, base);
    checkOutput("f3_instr", instr, 32'h2211F0AA);
    for (int i = 0; i < 4; i++) checkOutput("f3_adr", addr_log[base + i], exp_adr[i]);
    @(negedge clk);
    applyStimulus(OP_LDAB, 1'b0);
    checkOutput("ldab_ab", ab, 8'hF0);
    checkOutput("ldab_zero", zero, 0);
    repeat (3) @(negedge clk);
    checkOutput("instr_hold", instr, 32'h2211F0AA);

    doFetch(1'b1, 8'h10, cyc, base);
    @(negedge clk);
    applyStimulus(OP_LDBB, 1'b0);
    checkOutput("ldbb_bb", bb, 8'h20);
    applyStimulus(OP_ADD, 1'b0);
    checkOutput("add_ab", ab, 8'h10);
    checkOutput("add_cz", {carry, zero}, 2'b10);

    doFetch(1'b1, 8'h20, cyc, base);
    @(negedge clk);
    applyStimulus(OP_LDBB, 1'b0);
    checkOutput("ldbb2_bb", bb, 8'h10);
    applyStimulus(OP_SUB, 1'b0);
    checkOutput("sub_ab", ab, 8'h00);
    checkOutput("sub_cz", {carry, zero}, 2'b01);

    applyStimulus(OP_LDAB, 1'b0);
    checkOutput("ldab2_ab", ab, 8'h10);
    repeat (3) applyStimulus(OP_SHL, 1'b0);
    checkOutput("shl3_ab", ab, 8'h80);
    checkOutput("shl3_cz", {carry, zero}, 2'b00);
    applyStimulus(OP_SHL, 1'b0);
    checkOutput("shl4_ab", ab, 8'h00);
    checkOutput("shl4_cz", {carry, zero}, 2'b11);

    // Stack: push 10..80, overflow with 90, pop back in LIFO order.
    for (int k = 1; k <= 8; k++) begin
      applyStimulus(OP_ADD, 1'b0);
      applyStimulus(OP_PUSH, 1'b0);
    end
    checkOutput("push8_flags", {stack_full, stack_empty, stack_err}, 3'b100);
    applyStimulus(OP_ADD, 1'b0);
    applyStimulus(OP_PUSH, 1'b0);
    checkOutput("push9_flags", {stack_full, stack_empty, stack_err}, 3'b101);
    checkOutput("push9_ab", ab, 8'h90);
    for (int k = 8; k >= 1; k--) begin
      applyStimulus(OP_POP, 1'b0);
      checkOutput("pop_ab", ab, k * 16);
    end
    checkOutput("pop8_flags", {stack_full, stack_empty, carry}, 3'b010);
    applyStimulus(OP_POP, 1'b0);
    checkOutput("underflow_ab", ab, 8'h10);
    checkOutput("underflow_flags", {zero, stack_empty, stack_err}, 3'b011);
    applyStimulus(OP_NOP, 1'b1);
    checkOutput("err_clr", stack_err, 0);
    applyStimulus(OP_POP, 1'b1);
    checkOutput("err_wins", stack_err, 1);
    applyStimulus(OP_NOP, 1'b1);

    // Reset after two bytes of a fetch have been taken.
    pb = pulses;
    fetch_start = 1'b1;
    @(negedge clk);
    fetch_start = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("mid_req", mem_req, 1);
    reset = 1'b0;
    #1;
    checkOutput("mrst_ctl", {mem_req, instr_valid, busy}, 3'b000);
    checkOutput("mrst_ab_bb", {ab, bb}, 16'h0000);
    checkOutput("mrst_instr", instr, 0);
    checkOutput("mrst_flags", {zero, carry, stack_empty, stack_full, stack_err}, 5'b10100);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("mrst_no_pulse", pulses - pb, 0);
    checkOutput("mrst_idle", {busy, mem_req}, 2'b00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/acc_datapath_gen.md
ACC_DATAPATH_GEN -- requirements
Module: acc_datapath_gen

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning the data, accumulator and PC width (legal range 8..32).
REQ-002 The block SHALL have parameter INSTR_BYTES, default 4, meaning the instruction length in bytes (legal range 2..8).
REQ-003 The block SHALL have parameter STACK_DEPTH, default 8, meaning the number of stack entries (power of two, 2..64).
REQ-004 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-006 The block SHALL have port fetch_start, input, 1, request to fetch one instruction starting at pc.
REQ-007 The block SHALL have port pc_load, input, 1, load pc from pc_target.
REQ-008 The block SHALL have port pc_target, input, WIDTH, the new pc value.
REQ-009 The block SHALL have port mem_req, output, 1, byte read request.
REQ-010 The block SHALL have port mem_adr, output, WIDTH, the read address.
REQ-011 The block SHALL have port mem_ack, input, 1, read data valid this cycle.
REQ-012 The block SHALL have port mem_rdata, input, 8, the read byte.
REQ-013 The block SHALL have port instr, output, 8*INSTR_BYTES, the assembled instruction, byte 0 at bits [7:0].
REQ-014 The block SHALL have port instr_valid, output, 1, a one-cycle pulse when instr is complete.
REQ-015 The block SHALL have port busy, output, 1, high while a fetch is in progress.
REQ-016 The block SHALL have port exec_valid, input, 1, execute exec_op this cycle.
REQ-017 The block SHALL have port exec_op, input, 3, the operation code.
REQ-018 The block SHALL have port err_clr, input, 1, clear stack_err.
REQ-019 The block SHALL have ports ab and bb, output, WIDTH each, the accumulator and operand register.
REQ-020 The block SHALL have ports zero, carry, stack_full, stack_empty and stack_err, output, 1 each, the status flags.

Function
REQ-021 The fetch FSM SHALL have states IDLE, FETCH and DONE.
REQ-022 In IDLE, fetch_start SHALL clear the byte counter and move the FSM to FETCH.
REQ-023 In FETCH, mem_req SHALL be 1 and mem_adr SHALL equal pc.
REQ-024 In FETCH, each mem_ack cycle SHALL write mem_rdata into instr byte[cnt], increment pc and increment cnt.
REQ-025 The ack of byte INSTR_BYTES-1 SHALL move the FSM to DONE.
REQ-026 In DONE, instr_valid SHALL be 1 for exactly one cycle and the FSM SHALL then return to IDLE.
REQ-027 Outside FETCH, mem_req SHALL be 0 and mem_ack SHALL be ignored.
REQ-028 busy SHALL be 1 in FETCH and DONE.
REQ-029 fetch_start, pc_load and exec_valid SHALL be ignored while busy is 1.
REQ-030 pc SHALL wrap modulo 2^WIDTH, including in the middle of a fetch.
REQ-031 instr SHALL hold its value until the next fetch overwrites it byte by byte.
REQ-032 exec_valid in IDLE SHALL apply the operation selected by exec_op at the next clock edge, with single-cycle latency.
REQ-033 The exec_op encoding SHALL be: 0 NOP; 1 LDAB, ab=zero-extended instr[15:8]; 2 LDBB, bb=zero-extended instr[15:8]; 3 ADD; 4 SUB; 5 PUSH ab; 6 POP into ab; 7 SHL ab by 1.
REQ-034 ADD SHALL set ab=(ab+bb) mod 2^WIDTH and carry=carry-out of the addition.
REQ-035 SUB SHALL set ab=(ab-bb) mod 2^WIDTH and carry=1 when ab<bb (borrow).
REQ-036 SHL SHALL set carry=the old ab MSB.
REQ-037 LDAB and POP SHALL leave carry unchanged.
REQ-038 zero SHALL be updated on every ab-writing op to (new ab==0) and SHALL otherwise hold.
REQ-039 PUSH when stack_full SHALL leave the stack and ab unchanged and set stack_err.
REQ-040 POP when stack_empty SHALL leave ab, zero and the stack unchanged and set stack_err.
REQ-041 stack_err SHALL be sticky; err_clr SHALL clear it, and a same-cycle new error SHALL win over err_clr.
REQ-042 stack_full SHALL equal (count==STACK_DEPTH) and stack_empty SHALL equal (count==0), both registered.
REQ-043 Simultaneous fetch_start and pc_load in IDLE: pc_load SHALL take effect and the fetch SHALL start at pc_target.

Reset
REQ-044 On reset low, the block SHALL immediately force pc=0, ab=0, bb=0, instr=0, cnt=0, FSM=IDLE, zero=1, carry=0, stack count=0, stack_empty=1, stack_full=0 and stack_err=0.
REQ-045 The block SHALL drive mem_req=0, instr_valid=0 and busy=0 while reset is low.
REQ-046 A reset mid-fetch SHALL abandon the fetch with no instr_valid pulse.

Structure
REQ-047 The shared package SHALL hold the exec_op enum (NOP..SHL), the fetch-state enum, and the STACK_DEPTH, WIDTH and INSTR_BYTES defaults.
REQ-048 The stack SHALL be a sub-module lifo_stack (WIDTH, STACK_DEPTH) with push, pop, full, empty and err outputs.

Verification
REQ-049 Test: reset, then fetch_start with memory bytes 11,22,33,44 and ack every cycle -> instr=44332211, instr_valid pulses at cycle 6, pc=4.
REQ-050 Test: ack gaps of 0,3,1,2 idle cycles -> mem_req held high throughout and the same instr is assembled.
REQ-051 Test: LDAB 0xF0, LDBB 0x20, ADD -> ab=0x10, carry=1, zero=0; then SUB with bb=0x10 -> ab=0, zero=1, carry=0.
REQ-052 Test: 8 PUSH then a 9th -> stack_full=1, stack_err=1 and the stack intact; then 8 POP -> values returned in LIFO order and stack_empty=1.
REQ-053 Test: pc_load 0xFE then fetch of 4 bytes -> addresses FE,FF,00,01 are read.
REQ-054 Test: reset asserted at byte 2 of a fetch -> mem_req drops asynchronously, no instr_valid pulse, and all reset values hold.
